timer_irq_source: RTL and testbench



---
 rtl/timer_irq_source.sv | 167 ++++++++++++++++
 tb/tb_timer_irq_source.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped interval timer that raises a level
// interrupt on counter overflow. Registers: TH (+0x0) reload value,
// TL (+0x4) counter, TCON (+0x8) {IP, IE, EN}.
// Optional build macro TIMER_SYSTICK_EN adds a read-only free-running
// cycle counter SYSTICK at +0x14.
`timescale 1ns/1ps
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemRd,
  input  logic        MemWr,
  output logic [31:0] ReadData,
  output logic        Interrupt,
  output logic        hit
);

  localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        ip_q, ip_d;
  logic [15:0] presc_q, presc_d;
`ifdef TIMER_SYSTICK_EN
  logic [31:0] systick_q, systick_d;
`endif

  logic sel_th, sel_tl, sel_tcon, sel_systick;
  logic tick_s, overflow_s, set_ip_s, wr_s;

  // Address decode: word-aligned accesses inside the 32-byte window only.
  always_comb begin
    sel_th      = 1'b0;
    sel_tl      = 1'b0;
    sel_tcon    = 1'b0;
    sel_systick = 1'b0;
    if ((Addr[31:5] == BASE_ADDR[31:5]) && (Addr[1:0] == 2'b00)) begin
      case (Addr[4:2])
        3'd0:    sel_th   = 1'b1;
        3'd1:    sel_tl   = 1'b1;
        3'd2:    sel_tcon = 1'b1;
`ifdef TIMER_SYSTICK_EN
        3'd5:    sel_systick = 1'b1;
`endif
        default: sel_th   = 1'b0;
      endcase
    end else begin
      sel_th = 1'b0;
    end
  end

  assign hit  = sel_th | sel_tl | sel_tcon | sel_systick;
  assign wr_s = MemWr & hit;

  // Prescaler: counts while enabled, emits one tick per wrap, parked at 0 when disabled.
  always_comb begin
    tick_s  = 1'b0;
    presc_d = presc_q;
    if (en_q) begin
      if (presc_q == PRESCALE_MAX) begin
        presc_d = 16'd0;
        tick_s  = 1'b1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end else begin
      presc_d = 16'd0;
    end
  end

  // Register next-state: a TL store beats a tick, a TH store never affects
  // the reload happening on the same edge, and an overflow always wins over
  // a software clear of IP so no interrupt is lost.
  always_comb begin
    overflow_s = tick_s & (tl_q == 32'hFFFF_FFFF);
    set_ip_s   = overflow_s & ie_q & ~(wr_s & sel_tl);

    if (wr_s && sel_th) begin
      th_d = WriteData;
    end else begin
      th_d = th_q;
    end

    if (wr_s && sel_tl) begin
      tl_d = WriteData;
    end else if (overflow_s) begin
      tl_d = th_q;
    end else if (tick_s) begin
      tl_d = tl_q + 32'd1;
    end else begin
      tl_d = tl_q;
    end

    if (wr_s && sel_tcon) begin
      en_d = WriteData[0];
      ie_d = WriteData[1];
      ip_d = WriteData[2] | set_ip_s;
    end else begin
      en_d = en_q;
      ie_d = ie_q;
      ip_d = ip_q | set_ip_s;
    end
  end

`ifdef TIMER_SYSTICK_EN
  // Free-running cycle counter; wraps silently and ignores stores.
  always_comb begin
    systick_d = systick_q + 32'd1;
  end
`endif

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q    <= 32'd0;
      tl_q    <= 32'd0;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      ip_q    <= 1'b0;
      presc_q <= 16'd0;
`ifdef TIMER_SYSTICK_EN
      systick_q <= 32'd0;
`endif
    end else begin
      th_q    <= th_d;
      tl_q    <= tl_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      ip_q    <= ip_d;
      presc_q <= presc_d;
`ifdef TIMER_SYSTICK_EN
      systick_q <= systick_d;
`endif
    end
  end

  // Read mux: zero unless a decoded load is in progress.
  always_comb begin
    ReadData = 32'd0;
    if (MemRd) begin
      if (sel_th) begin
        ReadData = th_q;
      end else if (sel_tl) begin
        ReadData = tl_q;
      end else if (sel_tcon) begin
        ReadData = {29'd0, ip_q, ie_q, en_q};
`ifdef TIMER_SYSTICK_EN
      end else if (sel_systick) begin
        ReadData = systick_q;
`endif
      end else begin
        ReadData = 32'd0;
      end
    end else begin
      ReadData = 32'd0;
    end
  end

  assign Interrupt = ie_q & ip_q;

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed self-checking bench for timer_irq_source. Two instances share
// the bus inputs: one with PRESCALE=1 (u1) and one with PRESCALE=4 (u4).
// Inputs change on the falling edge; outputs are sampled there too.
`timescale 1ns/1ps
module tb_timer_irq_source;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_ST   = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4, hit1, hit4;

  logic [31:0] r1, r4, v, s1, s2;
  logic        h1, h4;
  int          n_tests = 0;
  int          n_fail  = 0;

  timer_irq_source #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .Addr(Addr), .WriteData(WriteData),
    .MemRd(MemRd), .MemWr(MemWr), .ReadData(rdata1), .Interrupt(irq1), .hit(hit1));

  timer_irq_source #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) u4 (
    .clk(clk), .reset(reset), .Addr(Addr), .WriteData(WriteData),
    .MemRd(MemRd), .MemWr(MemWr), .ReadData(rdata4), .Interrupt(irq4), .hit(hit4));

  always #10 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One store: the write lands on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a; WriteData = d; MemWr = 1'b1;
    @(negedge clk);
    MemWr = 1'b0; Addr = 32'd0; WriteData = 32'd0;
  endtask

  // One combinational load, no clock edge consumed.
  task automatic rd(input logic [31:0] a);
    Addr = a; MemRd = 1'b1;
    #1;
    r1 = rdata1; r4 = rdata4; h1 = hit1; h4 = hit4;
    MemRd = 1'b0; Addr = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    rd(A_TH);   n_tests++; if (r1 !== 32'd0 || h1 !== 1'b1) begin n_fail++; $display("FAIL reset_th: got %h/%b expected 0/1", r1, h1); end
    rd(A_TL);   n_tests++; if (r4 !== 32'd0 || h4 !== 1'b1) begin n_fail++; $display("FAIL reset_tl: got %h/%b expected 0/1", r4, h4); end
    rd(A_TCON); n_tests++; if (r1 !== 32'd0 || r4 !== 32'd0) begin n_fail++; $display("FAIL reset_tcon: got %h %h expected 0", r1, r4); end
    n_tests++; if (irq1 !== 1'b0 || irq4 !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b %b expected 0", irq1, irq4); end
    rd(32'h4000_000C); n_tests++; if (h1 !== 1'b0 || r1 !== 32'd0) begin n_fail++; $display("FAIL reset_undef_hit: got %b/%h expected 0/0", h1, r1); end
    rd(32'h4000_0001); n_tests++; if (h1 !== 1'b0) begin n_fail++; $display("FAIL subword_hit: got %b expected 0", h1); end
  endtask

  task automatic test_prescale1();
    wr(A_TCON, 32'd0); wr(A_TH, 32'hFFFF_FFFC); wr(A_TL, 32'hFFFF_FFFC); wr(A_TCON, 32'd3);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      n_tests++; if (irq1 !== 1'(k == 4)) begin n_fail++; $display("FAIL p1_rise cyc%0d: got %b expected %b", k, irq1, (k == 4)); end
    end
    rd(A_TL); n_tests++; if (r1 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL p1_reload: got %h expected fffffffc", r1); end
    wr(A_TCON, 32'd3);
    n_tests++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL p1_ack: got %b expected 0", irq1); end
    for (int k = 1; k <= 3; k++) begin
      step(1);
      n_tests++; if (irq1 !== 1'(k == 3)) begin n_fail++; $display("FAIL p1_rerise cyc%0d: got %b expected %b", k, irq1, (k == 3)); end
    end
  endtask

  task automatic test_prescale4();
    wr(A_TCON, 32'd0); wr(A_TH, 32'd0); wr(A_TL, 32'hFFFF_FFFE); wr(A_TCON, 32'd3);
    step(3); rd(A_TL); n_tests++; if (r4 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL p4_tl3: got %h expected fffffffe", r4); end
    step(1); rd(A_TL); n_tests++; if (r4 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL p4_tl4: got %h expected ffffffff", r4); end
    step(3); rd(A_TCON); n_tests++; if (r4 !== 32'd3) begin n_fail++; $display("FAIL p4_ip7: got %h expected 3", r4); end
    step(1); rd(A_TCON); n_tests++; if (r4 !== 32'd7 || irq4 !== 1'b1) begin n_fail++; $display("FAIL p4_ip8: got %h/%b expected 7/1", r4, irq4); end
    rd(A_TL); n_tests++; if (r4 !== 32'd0) begin n_fail++; $display("FAIL p4_reload: got %h expected 0", r4); end
  endtask

  task automatic test_ip_collision();
    wr(A_TCON, 32'd0); wr(A_TH, 32'd0); wr(A_TL, 32'hFFFF_FFFE); wr(A_TCON, 32'd3);
    step(1);
    n_tests++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL coll_pre: got %b expected 0", irq1); end
    wr(A_TCON, 32'd3);
    rd(A_TCON); n_tests++; if (r1 !== 32'd7 || irq1 !== 1'b1) begin n_fail++; $display("FAIL coll_ip: got %h/%b expected 7/1", r1, irq1); end
  endtask

  task automatic test_no_ie_swirq();
    wr(A_TCON, 32'd0); wr(A_TL, 32'hFFFF_FFFF); wr(A_TCON, 32'd1);
    step(1);
    rd(A_TCON); n_tests++; if (r1 !== 32'd1 || irq1 !== 1'b0) begin n_fail++; $display("FAIL noie_ip: got %h/%b expected 1/0", r1, irq1); end
    wr(A_TCON, 32'd7);
    n_tests++; if (irq1 !== 1'b1) begin n_fail++; $display("FAIL swirq: got %b expected 1", irq1); end
  endtask

  task automatic test_store_collisions();
    wr(A_TCON, 32'd0); wr(A_TH, 32'h50); wr(A_TL, 32'hFFFF_FFFE); wr(A_TCON, 32'd3);
    step(1);
    wr(A_TL, 32'h10);
    rd(A_TL); n_tests++; if (r1 !== 32'h10) begin n_fail++; $display("FAIL tl_store_wins: got %h expected 10", r1); end
    rd(A_TCON); n_tests++; if (r1 !== 32'd3) begin n_fail++; $display("FAIL tl_store_no_ip: got %h expected 3", r1); end
    wr(A_TCON, 32'd0); wr(A_TL, 32'hFFFF_FFFE); wr(A_TCON, 32'd3);
    step(1);
    wr(A_TH, 32'h77);
    rd(A_TL); n_tests++; if (r1 !== 32'h50) begin n_fail++; $display("FAIL th_old_reload: got %h expected 50", r1); end
    rd(A_TH); n_tests++; if (r1 !== 32'h77) begin n_fail++; $display("FAIL th_new: got %h expected 77", r1); end
    rd(A_TL); v = r1;
    wr(A_TCON, 32'd0);
    rd(A_TL); n_tests++; if (r1 !== v + 32'd1) begin n_fail++; $display("FAIL en_clear_tick: got %h expected %h", r1, v + 32'd1); end
    step(2);
    rd(A_TL); n_tests++; if (r1 !== v + 32'd1) begin n_fail++; $display("FAIL en_clear_hold: got %h expected %h", r1, v + 32'd1); end
  endtask

  task automatic test_decode();
    wr(32'h4000_000C, 32'hFFFF_FFFF); wr(32'h4000_0001, 32'h1234_5678); wr(32'h4000_0020, 32'hDEAD_BEEF);
    rd(A_TH); n_tests++; if (r1 !== 32'h77) begin n_fail++; $display("FAIL ignored_writes: got %h expected 77", r1); end
    rd(32'h4000_0020); n_tests++; if (h1 !== 1'b0 || r1 !== 32'd0) begin n_fail++; $display("FAIL outside_hit: got %b/%h expected 0/0", h1, r1); end
    Addr = A_TH; MemRd = 1'b0; #1;
    n_tests++; if (rdata1 !== 32'd0 || hit1 !== 1'b1) begin n_fail++; $display("FAIL no_rd_data: got %h/%b expected 0/1", rdata1, hit1); end
    Addr = 32'd0;
  endtask

  task automatic test_systick();
`ifdef TIMER_SYSTICK_EN
    rd(A_ST); s1 = r1;
    n_tests++; if (h1 !== 1'b1) begin n_fail++; $display("FAIL st_hit: got %b expected 1", h1); end
    step(10);
    rd(A_ST); s2 = r1;
    n_tests++; if (s2 - s1 !== 32'd10) begin n_fail++; $display("FAIL st_delta: got %0d expected 10", s2 - s1); end
    wr(A_ST, 32'd0);
    rd(A_ST);
    n_tests++; if (r1 !== s2 + 32'd1) begin n_fail++; $display("FAIL st_store_ignored: got %h expected %h", r1, s2 + 32'd1); end
`else
    rd(A_ST);
    n_tests++; if (h1 !== 1'b0 || r1 !== 32'd0) begin n_fail++; $display("FAIL st_absent: got %b/%h expected 0/0", h1, r1); end
`endif
  endtask

  task automatic test_mid_reset();
    wr(A_TCON, 32'd7);
    n_tests++; if (irq1 !== 1'b1) begin n_fail++; $display("FAIL mr_pre: got %b expected 1", irq1); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_tests++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL mr_irq: got %b expected 0", irq1); end
    rd(A_TCON); n_tests++; if (r1 !== 32'd0) begin n_fail++; $display("FAIL mr_tcon: got %h expected 0", r1); end
    rd(A_TH);   n_tests++; if (r1 !== 32'd0) begin n_fail++; $display("FAIL mr_th: got %h expected 0", r1); end
    rd(A_TL);   n_tests++; if (r1 !== 32'd0) begin n_fail++; $display("FAIL mr_tl: got %h expected 0", r1); end
  endtask

  initial begin
    reset = 1'b1; Addr = 32'd0; WriteData = 32'd0; MemRd = 1'b0; MemWr = 1'b0;
    test_reset();
    test_prescale1();
    test_prescale4();
    test_ip_collision();
    test_no_ie_swirq();
    test_store_collisions();
    test_decode();
    test_systick();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
